// File: rtl/decoder_feed_pkg.sv
// Shared definitions for the decoder feed arbiter: FSM encoding, error codes,
// parameter defaults and the completion status record.
package decoder_feed_pkg;

  localparam int TIMEOUT_DEF   = 256;
  localparam int MAX_WORDS_DEF = 16384;
  localparam int WCNT_W        = 14;
  localparam int NUM_SRC       = 2;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DRST     = 3'd1;
  localparam logic [2:0] ST_STREAM   = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_WAIT_FIN = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

  typedef struct packed {
    logic       src;
    logic       ok;
    logic [1:0] err;
  } pkt_status_t;

endpackage

// File: rtl/feed_rr_arb.sv
// Two-way round-robin grant. The pointer names the preferred source on a tie
// and moves away from the source that just completed.
module feed_rr_arb
  import decoder_feed_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  input  logic               done,
  input  logic               done_src,
  output logic               gnt
);

  logic ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    ptr <= 1'b0;
    else if (done) ptr <= ~done_src;
  end

  always_comb begin
    gnt = ptr;
    if (req == 2'b01)      gnt = 1'b0;
    else if (req == 2'b10) gnt = 1'b1;
  end

endmodule

// File: rtl/decoder_feed_arbiter.sv
// Streams whole packets from one of two requesters into a single decoder,
// resetting the decoder per packet and reporting completion status.
module decoder_feed_arbiter
  import decoder_feed_pkg::*;
#(
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic        last0,
  input  logic        last1,
  output logic        rd0,
  output logic        rd1,
  output logic [31:0] dec_data,
  output logic        dec_start,
  output logic        dec_reset,
  input  logic        dec_fin,
  input  logic        dec_ok,
  output logic        pkt_done,
  output logic        pkt_src,
  output logic        pkt_ok,
  output logic [1:0]  pkt_err
);

  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  logic [2:0]        state, state_d;
  logic              gnt, gnt_arb;
  logic [WCNT_W-1:0] wcnt;
  logic [TCNT_W-1:0] tcnt;
  logic              fin_q, fin_seen, fin_seen_d, ok_lat, ok_lat_d;
  logic [1:0]        err, err_d;
  logic              pop, pop_last, fin_rise, wcnt_full;
  logic [31:0]       pop_word;
  pkt_status_t       stat;

  feed_rr_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      ({req1, req0}),
    .done     (pkt_done),
    .done_src (gnt),
    .gnt      (gnt_arb)
  );

  assign pop       = (state == ST_STREAM) || (state == ST_DRAIN);
  assign pop_word  = gnt ? data1 : data0;
  assign pop_last  = gnt ? last1 : last0;
  assign rd0       = pop & ~gnt;
  assign rd1       = pop & gnt;
  assign dec_reset = (state == ST_DRST);
  assign pkt_done  = (state == ST_DONE);
  assign fin_rise  = dec_fin & ~fin_q;
  assign wcnt_full = (wcnt == WCNT_W'(MAX_WORDS - 1));

  assign pkt_src = stat.src;
  assign pkt_ok  = stat.ok;
  assign pkt_err = stat.err;

  always_comb begin
    state_d    = state;
    fin_seen_d = fin_seen;
    ok_lat_d   = ok_lat;
    err_d      = err;
    if ((state == ST_STREAM || state == ST_WAIT_FIN) && fin_rise) begin
      fin_seen_d = 1'b1;
      ok_lat_d   = dec_ok;
    end
    case (state)
      ST_IDLE:   if (req0 | req1) state_d = ST_DRST;
      ST_DRST: begin
        state_d    = ST_STREAM;
        fin_seen_d = 1'b0;
        ok_lat_d   = 1'b0;
        err_d      = ERR_NONE;
      end
      ST_STREAM: begin
        if (pop_last) state_d = ST_WAIT_FIN;
        else if (wcnt_full) begin
          err_d   = ERR_OVERFLOW;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN:  if (pop_last) state_d = ST_DONE;
      ST_WAIT_FIN: begin
        if (fin_seen) state_d = ST_DONE;
        else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_DONE;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      gnt       <= 1'b0;
      wcnt      <= '0;
      tcnt      <= '0;
      fin_q     <= 1'b0;
      fin_seen  <= 1'b0;
      ok_lat    <= 1'b0;
      err       <= ERR_NONE;
      dec_data  <= '0;
      dec_start <= 1'b0;
      stat      <= '0;
    end else begin
      state    <= state_d;
      fin_q    <= dec_fin;
      fin_seen <= fin_seen_d;
      ok_lat   <= ok_lat_d;
      err      <= err_d;
      if (state == ST_IDLE && (req0 | req1)) gnt <= gnt_arb;
      wcnt <= (state == ST_STREAM) ? wcnt + 1'b1 : '0;
      tcnt <= (state == ST_WAIT_FIN) ? tcnt + 1'b1 : '0;
      // Words popped while draining an overflowed packet never reach the decoder.
      dec_start <= (state == ST_STREAM);
      dec_data  <= (state == ST_STREAM) ? pop_word : '0;
      // Status is loaded on DONE entry so it is already valid during the pulse.
      if (state_d == ST_DONE && state != ST_DONE) begin
        stat.src <= gnt;
        stat.ok  <= (err_d == ERR_NONE) && ok_lat_d;
        stat.err <= err_d;
      end
    end
  end

endmodule
